// File: rtl/aer_pkg.sv
// Shared definitions for the AER rate encoder: event type codes, FSM states
// and the packed-coordinate width helpers.
package aer_pkg;

    localparam logic [1:0] AER_SPIKE   = 2'b00;
    localparam logic [1:0] AER_TS_END  = 2'b01;
    localparam logic [1:0] AER_SMP_END = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_EVAL,
        S_REQ_HI,
        S_REQ_LO,
        S_TS_END,
        S_SMP_END,
        S_WAIT_FIN,
        S_DONE
    } enc_state_t;

    function automatic int aer_cw(input int fm_c, input int fm_h, input int fm_w);
        return $clog2(fm_c) + $clog2(fm_h) + $clog2(fm_w);
    endfunction

    // Counters need at least one bit even when a dimension is 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_dual_ram.sv
// One-write/one-read synchronous RAM with a registered read port (1-cycle latency).
module enc_dual_ram #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/aer_rate_encoder.sv
// Integrate-and-fire rate encoder: scans a stored image TIME_STEP times and
// emits spikes plus timestep/sample markers on a 4-phase AER req/ack link.
module aer_rate_encoder
    import aer_pkg::*;
#(
    parameter int FM_W      = 16,
    parameter int FM_H      = 16,
    parameter int FM_C      = 3,
    parameter int TIME_STEP = 8,
    parameter int PIX_WIDTH = 8,
    parameter int ACC_INIT  = 2**(PIX_WIDTH-1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [aer_cw(FM_C, FM_H, FM_W)-1:0] cfg_addr,
    input  logic [PIX_WIDTH-1:0]                cfg_data,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                AEROUT_REQ,
    output logic [aer_cw(FM_C, FM_H, FM_W)+1:0] AEROUT_ADDR,
    input  logic                                AEROUT_ACK,
    input  logic                                ONE_SAMPLE_FINISH
);

    localparam int CW = aer_cw(FM_C, FM_H, FM_W);
    localparam int XB = $clog2(FM_W);
    localparam int YB = $clog2(FM_H);
    localparam int XW = cnt_w(FM_W);
    localparam int YW = cnt_w(FM_H);
    localparam int CB = cnt_w(FM_C);
    localparam int TW = cnt_w(TIME_STEP);

    localparam logic [XW-1:0]        X_LAST     = XW'(FM_W - 1);
    localparam logic [YW-1:0]        Y_LAST     = YW'(FM_H - 1);
    localparam logic [CB-1:0]        C_LAST     = CB'(FM_C - 1);
    localparam logic [TW-1:0]        T_LAST     = TW'(TIME_STEP - 1);
    localparam logic [PIX_WIDTH-1:0] ACC_INIT_V = PIX_WIDTH'(ACC_INIT);

    enc_state_t state, state_n;

    logic [XW-1:0] x_cnt, x_n, x_adv;
    logic [YW-1:0] y_cnt, y_n, y_adv;
    logic [CB-1:0] c_cnt, c_n, c_adv;
    logic [TW-1:0] t_cnt, t_n;
    logic [1:0]    ret_type, ret_n;
    logic          req_n, busy_n, done_n;
    logic [CW+1:0] addr_n;
    logic          last_pix;

    logic [CW-1:0]        coord;
    logic [PIX_WIDTH-1:0] pix_rdata, acc_rdata, acc_base;
    logic [PIX_WIDTH:0]   sum;
    logic                 pix_we, acc_we;

    // Zero-width fields (a dimension of 1) collapse naturally with shifts.
    assign coord = (CW'(c_cnt) << (XB + YB)) | (CW'(y_cnt) << XB) | CW'(x_cnt);

    assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST) && (c_cnt == C_LAST);
    assign acc_base = (t_cnt == '0) ? ACC_INIT_V : acc_rdata;
    assign sum      = {1'b0, acc_base} + {1'b0, pix_rdata};
    assign pix_we   = (state == S_IDLE) && cfg_we;

    enc_dual_ram #(.AW(CW), .DW(PIX_WIDTH)) u_pix_ram (
        .clk   (clk),
        .we    (pix_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (coord),
        .rdata (pix_rdata)
    );

    enc_dual_ram #(.AW(CW), .DW(PIX_WIDTH)) u_acc_ram (
        .clk   (clk),
        .we    (acc_we),
        .waddr (coord),
        .wdata (sum[PIX_WIDTH-1:0]),
        .raddr (coord),
        .rdata (acc_rdata)
    );

    always_comb begin
        x_adv = x_cnt + 1'b1;
        y_adv = y_cnt;
        c_adv = c_cnt;
        if (x_cnt == X_LAST) begin
            x_adv = '0;
            y_adv = y_cnt + 1'b1;
            if (y_cnt == Y_LAST) begin
                y_adv = '0;
                c_adv = (c_cnt == C_LAST) ? '0 : c_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x_cnt;
        y_n     = y_cnt;
        c_n     = c_cnt;
        t_n     = t_cnt;
        ret_n   = ret_type;
        req_n   = AEROUT_REQ;
        addr_n  = AEROUT_ADDR;
        busy_n  = busy;
        done_n  = 1'b0;
        acc_we  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RD;
                    x_n     = '0;
                    y_n     = '0;
                    c_n     = '0;
                    t_n     = '0;
                    busy_n  = 1'b1;
                end
            end
            S_RD: state_n = S_EVAL;
            S_EVAL: begin
                acc_we = 1'b1;
                if (sum[PIX_WIDTH]) begin
                    addr_n  = {AER_SPIKE, coord};
                    ret_n   = AER_SPIKE;
                    req_n   = !AEROUT_ACK;
                    state_n = S_REQ_HI;
                end else begin
                    x_n     = x_adv;
                    y_n     = y_adv;
                    c_n     = c_adv;
                    state_n = last_pix ? S_TS_END : S_RD;
                end
            end
            // REQ is raised only once a lingering ACK from the previous event has dropped.
            S_REQ_HI: begin
                if (!AEROUT_REQ) begin
                    if (!AEROUT_ACK) begin
                        req_n = 1'b1;
                    end
                end else if (AEROUT_ACK) begin
                    req_n   = 1'b0;
                    state_n = S_REQ_LO;
                end
            end
            S_REQ_LO: begin
                if (!AEROUT_ACK) begin
                    case (ret_type)
                        AER_SPIKE: begin
                            x_n     = x_adv;
                            y_n     = y_adv;
                            c_n     = c_adv;
                            state_n = last_pix ? S_TS_END : S_RD;
                        end
                        AER_TS_END: begin
                            if (t_cnt == T_LAST) begin
                                state_n = S_SMP_END;
                            end else begin
                                t_n     = t_cnt + 1'b1;
                                state_n = S_RD;
                            end
                        end
                        default: state_n = S_WAIT_FIN;
                    endcase
                end
            end
            S_TS_END: begin
                addr_n  = {AER_TS_END, {CW{1'b0}}};
                ret_n   = AER_TS_END;
                req_n   = !AEROUT_ACK;
                state_n = S_REQ_HI;
            end
            S_SMP_END: begin
                addr_n  = {AER_SMP_END, {CW{1'b0}}};
                ret_n   = AER_SMP_END;
                req_n   = !AEROUT_ACK;
                state_n = S_REQ_HI;
            end
            S_WAIT_FIN: begin
                if (ONE_SAMPLE_FINISH) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            c_cnt       <= '0;
            t_cnt       <= '0;
            ret_type    <= AER_SPIKE;
            AEROUT_REQ  <= 1'b0;
            AEROUT_ADDR <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            x_cnt       <= x_n;
            y_cnt       <= y_n;
            c_cnt       <= c_n;
            t_cnt       <= t_n;
            ret_type    <= ret_n;
            AEROUT_REQ  <= req_n;
            AEROUT_ADDR <= addr_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Scoreboard bench: a closed-form spike model fills an expected-event queue and an
// independent monitor pops it on every AER request rise and on every done pulse.
module tb_aer_rate_encoder;

    localparam int W        = 3;
    localparam int H        = 2;
    localparam int C        = 2;
    localparam int TS       = 8;
    localparam int PW       = 8;
    localparam int CW       = 4;
    localparam int NPIX     = W * H * C;
    localparam int ACC0     = 1 << (PW - 1);
    localparam int DONE_TOK = 'h1000;
    localparam int NONE_TOK = 'h2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [CW-1:0] cfg_addr;
    logic [PW-1:0] cfg_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          AEROUT_REQ;
    logic [CW+1:0] AEROUT_ADDR;
    logic          AEROUT_ACK;
    logic          ONE_SAMPLE_FINISH;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int got_q[$];
    int first_q[$];
    int spk_seen = 0;
    int ts_seen  = 0;
    int img[NPIX];
    int ack_dly_min = 0;
    int ack_dly_max = 0;
    int rel_dly_max = 0;
    bit record_en   = 1'b0;

    always #5 clk = ~clk;

    aer_rate_encoder #(
        .FM_W(W), .FM_H(H), .FM_C(C), .TIME_STEP(TS), .PIX_WIDTH(PW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .AEROUT_REQ        (AEROUT_REQ),
        .AEROUT_ADDR       (AEROUT_ADDR),
        .AEROUT_ACK        (AEROUT_ACK),
        .ONE_SAMPLE_FINISH (ONE_SAMPLE_FINISH)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int coord_of(input int c, input int y, input int x);
        return (c << 3) | (y << 2) | x;
    endfunction

    // A pixel fires at step t when its running total ACC0 + t*p crosses a multiple of 2**PW.
    function automatic bit spikes_at(input int p, input int t);
        return ((ACC0 + (t + 1) * p) / 256) > ((ACC0 + t * p) / 256);
    endfunction

    task automatic write_pixel(input int a, input int d);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = CW'(a);
        cfg_data = PW'(d);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Addresses with x beyond the map width get a value that would always spike if scanned.
    task automatic load_image();
        for (int c = 0; c < C; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < 4; x++)
                    write_pixel(coord_of(c, y, x), (x < W) ? img[c*H*W + y*W + x] : 255);
    endtask

    task automatic applyStimulus();
        for (int t = 0; t < TS; t++) begin
            for (int c = 0; c < C; c++)
                for (int y = 0; y < H; y++)
                    for (int x = 0; x < W; x++)
                        if (spikes_at(img[c*H*W + y*W + x], t))
                            exp_q.push_back(coord_of(c, y, x));
            exp_q.push_back(1 << CW);
        end
        exp_q.push_back(2 << CW);
        exp_q.push_back(DONE_TOK);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_sample_end(input int budget);
        int n = 0;
        while (!(exp_q.size() == 1 && !AEROUT_REQ && !AEROUT_ACK) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checkOutput("sample_end_reached", 0, 1);
            exp_q.delete();
            exp_q.push_back(DONE_TOK);
        end
        @(negedge clk);
    endtask

    task automatic finish_sample();
        repeat (3) @(negedge clk);
        checkOutput("wait_fin_no_done", int'(done), 0);
        checkOutput("wait_fin_busy", int'(busy), 1);
        ONE_SAMPLE_FINISH = 1'b1;
        @(negedge clk);
        ONE_SAMPLE_FINISH = 1'b0;
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("busy_at_done", int'(busy), 0);
        @(negedge clk);
        checkOutput("done_single_cycle", int'(done), 0);
        checkOutput("queue_drained", exp_q.size(), 0);
    endtask

    // Layer model: acknowledges each request and releases after randomised delays.
    initial begin : responder
        int d;
        AEROUT_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (AEROUT_REQ && !AEROUT_ACK) begin
                d = $urandom_range(ack_dly_max, ack_dly_min);
                repeat (d) @(negedge clk);
                AEROUT_ACK = 1'b1;
            end else if (!AEROUT_REQ && AEROUT_ACK) begin
                d = $urandom_range(rel_dly_max, 0);
                repeat (d) @(negedge clk);
                AEROUT_ACK = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic          prev_req;
        logic          prev_ack;
        logic [CW+1:0] prev_addr;
        int            e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (AEROUT_REQ && !prev_req) begin
                    checkOutput("req_rise_ack_low", int'(prev_ack), 0);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOK;
                    checkOutput("event", int'(AEROUT_ADDR), e);
                    if (AEROUT_ADDR[CW+1:CW] == 2'b00) spk_seen++;
                    else if (AEROUT_ADDR[CW+1:CW] == 2'b01) ts_seen++;
                    if (record_en) got_q.push_back(int'(AEROUT_ADDR));
                end else if (AEROUT_REQ) begin
                    checkOutput("addr_stable", int'(AEROUT_ADDR), int'(prev_addr));
                end
                if (done) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOK;
                    checkOutput("done_event", DONE_TOK, e);
                end
            end
            prev_req  = AEROUT_REQ;
            prev_ack  = AEROUT_ACK;
            prev_addr = AEROUT_ADDR;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        rst               = 1'b0;
        cfg_we            = 1'b0;
        cfg_addr          = '0;
        cfg_data          = '0;
        start             = 1'b0;
        ONE_SAMPLE_FINISH = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_req", int'(AEROUT_REQ), 0);
        checkOutput("reset_addr", int'(AEROUT_ADDR), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        rst = 1'b1;

        // All pixels saturated: every pixel fires every timestep.
        foreach (img[i]) img[i] = 255;
        load_image();
        spk_seen = 0;
        ts_seen  = 0;
        applyStimulus();
        wait_sample_end(5000);
        finish_sample();
        checkOutput("run1_spikes", spk_seen, NPIX * TS);
        checkOutput("run1_ts_markers", ts_seen, TS);

        // Sparse image, slow ack, plus a premature finish pulse mid-scan.
        foreach (img[i]) img[i] = 0;
        img[0]  = 128;
        img[11] = 64;
        ack_dly_min = 5;
        ack_dly_max = 5;
        rel_dly_max = 3;
        load_image();
        spk_seen = 0;
        ts_seen  = 0;
        applyStimulus();
        repeat (20) @(negedge clk);
        ONE_SAMPLE_FINISH = 1'b1;
        @(negedge clk);
        ONE_SAMPLE_FINISH = 1'b0;
        checkOutput("early_finish_busy", int'(busy), 1);
        wait_sample_end(5000);
        finish_sample();
        checkOutput("run2_spikes", spk_seen, 6);
        checkOutput("run2_ts_markers", ts_seen, TS);

        // Random image; cfg_we and start while busy must be ignored, rerun must match.
        foreach (img[i]) img[i] = int'($urandom_range(255, 0));
        ack_dly_min = 0;
        ack_dly_max = 5;
        rel_dly_max = 5;
        load_image();
        got_q.delete();
        record_en = 1'b1;
        applyStimulus();
        repeat (10) @(negedge clk);
        write_pixel(coord_of(0, 0, 0), 255 - img[0]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_sample_end(5000);
        finish_sample();
        record_en = 1'b0;
        first_q = got_q;
        got_q.delete();
        ack_dly_max = 3;
        rel_dly_max = 2;
        record_en = 1'b1;
        applyStimulus();
        wait_sample_end(5000);
        finish_sample();
        record_en = 1'b0;
        checkOutput("rerun_len", got_q.size(), first_q.size());
        for (int i = 0; i < got_q.size() && i < first_q.size(); i++)
            checkOutput("rerun_event", got_q[i], first_q[i]);

        // Reset while a request is outstanding, then a clean full sample.
        foreach (img[i]) img[i] = 255;
        ack_dly_min = 6;
        ack_dly_max = 6;
        rel_dly_max = 0;
        load_image();
        applyStimulus();
        n = 0;
        while (!AEROUT_REQ && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen_before_reset", int'(AEROUT_REQ), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_req", int'(AEROUT_REQ), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        rst = 1'b1;
        exp_q.delete();
        n = 0;
        while (!AEROUT_ACK && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (AEROUT_ACK && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ack_released", int'(AEROUT_ACK), 0);
        ack_dly_min = 0;
        ack_dly_max = 2;
        rel_dly_max = 2;
        spk_seen = 0;
        ts_seen  = 0;
        applyStimulus();
        wait_sample_end(5000);
        finish_sample();
        checkOutput("run5_spikes", spk_seen, NPIX * TS);
        checkOutput("run5_ts_markers", ts_seen, TS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
